// File: rtl/gps_if_pkg.sv
// gps_if_monitor shared types and constants.
// State encoding, readout word indices, WIN_BITS bounds.
package gps_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] IDX_IS = 2'd0;
  localparam logic [1:0] IDX_IM = 2'd1;
  localparam logic [1:0] IDX_QS = 2'd2;
  localparam logic [1:0] IDX_QM = 2'd3;

  localparam int WIN_BITS_MIN = 4;
  localparam int WIN_BITS_MAX = 15;

endpackage

// File: rtl/gps_sync2.sv
// Two-flop synchronizer for one asynchronous bit.
// Async active-low reset clears both stages.
module gps_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // capture stage then settle stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/gps_if_monitor.sv
// Front-end sample conditioning and occupancy windows.
// Syncs 2-bit ADC I/Q, counts sign/mag ones per window.
module gps_if_monitor
  import gps_if_pkg::*;
#(
  parameter int WIN_BITS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_sign_a,
  input  logic        I_mag_a,
  input  logic        Q_sign_a,
  input  logic        Q_mag_a,
  output logic        I_sign,
  output logic        I_mag,
  output logic        Q_sign,
  output logic        Q_mag,
  input  logic        win_start,
  input  logic        rd,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout
);

  localparam int CW = WIN_BITS + 1;
  localparam logic [WIN_BITS-1:0] LAST = '1;

  if (WIN_BITS < WIN_BITS_MIN || WIN_BITS > WIN_BITS_MAX) begin : g_bad_win
    $error("gps_if_monitor: WIN_BITS out of range");
  end

  logic s_is, s_im, s_qs, s_qm;

  gps_sync2 u_sync_is (.clk(clk), .rst_n(rst_n), .d(I_sign_a), .q(s_is));
  gps_sync2 u_sync_im (.clk(clk), .rst_n(rst_n), .d(I_mag_a),  .q(s_im));
  gps_sync2 u_sync_qs (.clk(clk), .rst_n(rst_n), .d(Q_sign_a), .q(s_qs));
  gps_sync2 u_sync_qm (.clk(clk), .rst_n(rst_n), .d(Q_mag_a),  .q(s_qm));

  // output register after the synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      I_sign <= 1'b0;
      I_mag  <= 1'b0;
      Q_sign <= 1'b0;
      Q_mag  <= 1'b0;
    end else begin
      I_sign <= s_is;
      I_mag  <= s_im;
      Q_sign <= s_qs;
      Q_mag  <= s_qm;
    end
  end

  state_t state_q, state_d;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic [WIN_BITS-1:0] smp_q;

  // next state; a restart always beats the final edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_start) state_d = RUN;
      RUN:     if (!win_start && smp_q == LAST) state_d = DONE;
      DONE:    if (win_start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  logic [CW-1:0] cnt_is, cnt_im, cnt_qs, cnt_qm;

  // window counters; restart cycle's sample is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_is <= '0;
      cnt_im <= '0;
      cnt_qs <= '0;
      cnt_qm <= '0;
      smp_q  <= '0;
    end else if (win_start) begin
      cnt_is <= '0;
      cnt_im <= '0;
      cnt_qs <= '0;
      cnt_qm <= '0;
      smp_q  <= '0;
    end else if (state_q == RUN) begin
      cnt_is <= cnt_is + CW'(I_sign);
      cnt_im <= cnt_im + CW'(I_mag);
      cnt_qs <= cnt_qs + CW'(Q_sign);
      cnt_qm <= cnt_qm + CW'(Q_mag);
      smp_q  <= smp_q + WIN_BITS'(1);
    end
  end

  logic [1:0] rd_ptr;

  // readout pointer; win_start takes priority over rd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rd_ptr <= IDX_IS;
    else if (win_start) rd_ptr <= IDX_IS;
    else if (rd)        rd_ptr <= rd_ptr + 2'd1;
  end

  // live readout mux, zero-extended to 16 bits
  always_comb begin
    dout = '0;
    unique case (rd_ptr)
      IDX_IS:  dout[CW-1:0] = cnt_is;
      IDX_IM:  dout[CW-1:0] = cnt_im;
      IDX_QS:  dout[CW-1:0] = cnt_qs;
      IDX_QM:  dout[CW-1:0] = cnt_qm;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_gps_if_monitor.sv
// Directed scoreboard bench for gps_if_monitor.
// WIN_BITS=4: 16-sample windows.
module tb_gps_if_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        I_sign_a, I_mag_a, Q_sign_a, Q_mag_a;
  logic        I_sign, I_mag, Q_sign, Q_mag;
  logic        win_start, rd;
  logic        busy, done;
  logic [15:0] dout;

  int passed = 0;
  int total  = 0;
  bit tog    = 1'b0;
  logic [15:0] exp_q[$];

  gps_if_monitor #(.WIN_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_sign_a(I_sign_a), .I_mag_a(I_mag_a),
    .Q_sign_a(Q_sign_a), .Q_mag_a(Q_mag_a),
    .I_sign(I_sign), .I_mag(I_mag),
    .Q_sign(Q_sign), .Q_mag(Q_mag),
    .win_start(win_start), .rd(rd),
    .busy(busy), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %0d, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) I_sign_a = ~I_sign_a;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_win();
    win_start = 1'b1;
    tick();
    win_start = 1'b0;
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // edges until done rises, bounded
  task automatic edges_to_done(output int n);
    n = 0;
    while (!done && n < 64) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    win_start = 1'b0;
    rd = 1'b0;
    I_sign_a = 1'b1; I_mag_a = 1'b1;
    Q_sign_a = 1'b1; Q_mag_a = 1'b1;
    ticks(4);

    push(16'd0); chk("rst_outs", {12'd0, I_sign, I_mag, Q_sign, Q_mag});
    push(16'd0); chk("rst_dout", dout);
    push(16'd0); chk("rst_flags", {14'd0, busy, done});

    I_sign_a = 1'b0; I_mag_a = 1'b0;
    Q_sign_a = 1'b0; Q_mag_a = 1'b0;
    rst_n = 1'b1;
    ticks(4);
    I_sign_a = 1'b1;
    ticks(2);
    push(16'd0); chk("lat_edge2", {15'd0, I_sign});
    tick();
    push(16'd1); chk("lat_edge3", {15'd0, I_sign});

    I_mag_a = 1'b1;
    tog = 1'b1;
    ticks(4);
    start_win();
    push(16'd1); chk("win_busy", {15'd0, busy});
    edges_to_done(n);
    push(16'd16); chk("win_len", 16'(n));
    push(16'd0); chk("win_busy_end", {15'd0, busy});
    push(16'd8);  chk("w0_is", dout);
    rd_pulse();
    push(16'd16); chk("w1_im", dout);
    rd_pulse();
    push(16'd0);  chk("w2_qs", dout);
    rd_pulse();
    push(16'd0);  chk("w3_qm", dout);
    rd_pulse();
    push(16'd8);  chk("w_wrap", dout);

    start_win();
    ticks(10);
    start_win();
    push(16'd1); chk("rst_win_busy", {15'd0, busy});
    edges_to_done(n);
    push(16'd16); chk("restart_len", 16'(n));
    push(16'd8);  chk("restart_is", dout);
    rd_pulse();
    push(16'd16); chk("restart_im", dout);

    start_win();
    ticks(15);
    win_start = 1'b1;
    rd = 1'b1;
    tick();
    win_start = 1'b0;
    rd = 1'b0;
    push(16'd2); chk("coll_flags", {14'd0, busy, done});
    edges_to_done(n);
    push(16'd16); chk("coll_len", 16'(n));
    push(16'd8);  chk("coll_ptr0", dout);

    rd_pulse();
    start_win();
    ticks(7);
    rst_n = 1'b0;
    #1;
    push(16'd0); chk("arst_flags", {14'd0, busy, done});
    push(16'd0); chk("arst_dout", dout);
    push(16'd0); chk("arst_outs", {12'd0, I_sign, I_mag, Q_sign, Q_mag});
    tick();
    rst_n = 1'b1;

    tog = 1'b0;
    I_sign_a = 1'b0; I_mag_a = 1'b0;
    Q_sign_a = 1'b1; Q_mag_a = 1'b0;
    ticks(4);
    start_win();
    edges_to_done(n);
    push(16'd16); chk("qs_len", 16'(n));
    I_sign_a = 1'b1; I_mag_a = 1'b1;
    Q_sign_a = 1'b0; Q_mag_a = 1'b1;
    ticks(5);
    push(16'd1); chk("qs_done_hold", {15'd0, done});
    push(16'd0);  chk("qs_w0", dout);
    rd_pulse();
    push(16'd0);  chk("qs_w1", dout);
    rd_pulse();
    push(16'd16); chk("qs_w2", dout);
    rd_pulse();
    push(16'd0);  chk("qs_w3", dout);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
